// File: rtl/m_data_mem_pkg.sv
// m_data_mem_pkg
//   Shared encodings for the MEM-stage data memory: store/load access types,
//   the clear-sweep FSM states, and alignment helpers used by m_data_mem.
package m_data_mem_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } load_type_e;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // Stores: sw needs word alignment, sh half alignment; sb and reserved never flag.
  function automatic logic store_misaligned(input logic [1:0] st, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (st)
      ST_SW:   mis = (lane != 2'b00);
      ST_SH:   mis = lane[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Loads: unlisted encodings behave as lw, so they need word alignment too.
  function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (lt)
      LD_LH, LD_LHU: mis = lane[0];
      LD_LB, LD_LBU: mis = 1'b0;
      default:       mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/m_lane_merge.sv
// m_lane_merge
//   Combinational read-modify-write merge for partial stores.
//   old_word   in  32  current array word
//   wdata      in  32  store data (low byte/half used for sb/sh)
//   store_type in  2   ST_SW / ST_SH / ST_SB / ST_RSV
//   lane       in  2   byte address bits [1:0]
//   merged     out 32  word to write back (old_word for reserved type)
module m_lane_merge
  import m_data_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_type,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (store_type)
      ST_SW: merged = wdata;
      ST_SH: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      ST_SB: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/m_data_mem.sv
// m_data_mem
//   MEM-stage data memory with byte/half/word stores (read-modify-write lane
//   merge) and sign/zero-extended loads. After every reset the whole array is
//   cleared one word per cycle while busy is high.
//   clk        in  1   rising-edge clock
//   reset      in  1   asynchronous active-low reset
//   mem_write  in  1   store valid this cycle
//   store_type in  2   00 sw, 01 sh, 10 sb, 11 reserved (no write)
//   load_type  in  3   000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others lw
//   addr       in  32  byte address; bits [ADDR_WIDTH+1:2] index the array
//   wdata      in  32  store data
//   rdata      out 32  extended load data (0 while clearing)
//   busy       out 1   clear sweep in progress
//   addr_err   out 1   misaligned access (0 while clearing)
module m_data_mem
  import m_data_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;
  logic [31:0]           merged;
  logic                  st_mis;
  logic                  ld_mis;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wd;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  // Upper address bits alias onto the array by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  assign idx     = addr[ADDR_WIDTH+1:2];
  assign lane    = addr[1:0];
  assign rd_word = mem[idx];
  assign st_mis  = store_misaligned(store_type, lane);
  assign ld_mis  = load_misaligned(load_type, lane);
  assign busy    = (state_q == S_CLEAR);

  m_lane_merge u_lane_merge (
    .old_word   (rd_word),
    .wdata      (wdata),
    .store_type (store_type),
    .lane       (lane),
    .merged     (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Single write port shared by the clear sweep and pipeline stores.
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wd    = merged;
    if (state_q == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt_q;
      wd    = '0;
    end else if (mem_write && (store_type != ST_RSV) && !st_mis) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wd;
  end

  // The error source follows the access kind: stores when mem_write, else loads.
  always_comb begin
    addr_err = 1'b0;
    if (state_q == S_RUN) begin
      if (mem_write) addr_err = st_mis;
      else           addr_err = ld_mis;
    end
  end

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (load_type)
      LD_LH:   rdata = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  rdata = {16'h0, half_sel};
      LD_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  rdata = {24'h0, byte_sel};
      default: rdata = rd_word;
    endcase

    if (state_q == S_CLEAR) rdata = '0;
  end

endmodule

// File: tb/tb_m_data_mem.sv
module tb_m_data_mem;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [1:0]  store_type;
  logic [2:0]  load_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;

  int n_checks;
  int n_fail;

  m_data_mem #(.ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .store_type (store_type),
    .load_type  (load_type),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic idle();
    mem_write  = 1'b0;
    store_type = 2'b00;
    load_type  = 3'b000;
    addr       = 32'h0;
    wdata      = 32'h0;
  endtask

  // Counts rising edges with busy high after reset release; bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic read_word(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    idle();
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [1:0] s,
                              input logic [2:0] l, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.we = w; v.st = s; v.lt = l; v.a = a; v.wd = d;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    idle();
    reset = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h1);
    check("reset_rdata", rdata, 32'h0);

    // Sweep: a store attempted throughout must be ignored
    mem_write = 1'b1; store_type = 2'b00; addr = 32'h0; wdata = 32'hDEADBEEF;
    reset = 1'b1;
    #1;
    check("sweep_busy_start", {31'h0, busy}, 32'h1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 10) begin
        addr = 32'h2;
        #1;
        check("sweep_err_forced0", {31'h0, addr_err}, 32'h0);
        addr = 32'h0;
      end
      if (cnt == 500) check("sweep_rdata_forced0", rdata, 32'h0);
      if (cnt == 1000) mem_write = 1'b0;
    end
    check("sweep_len", cnt, 1024);
    read_word("sweep_store_ignored", 32'h0, 32'h0);

    // Table-driven vectors; rdata/addr_err sampled before the edge commits a store
    vecs.push_back(mk("sw_10",        1, 2'b00, 3'b000, 32'h10,   32'h11223344, 32'h0,        0));
    vecs.push_back(mk("sb_12",        1, 2'b10, 3'b000, 32'h12,   32'h000000AA, 32'h11223344, 0));
    vecs.push_back(mk("lw_10",        0, 2'b00, 3'b000, 32'h10,   32'h0,        32'h11AA3344, 0));
    vecs.push_back(mk("lb_12",        0, 2'b00, 3'b011, 32'h12,   32'h0,        32'hFFFFFFAA, 0));
    vecs.push_back(mk("lbu_12",       0, 2'b00, 3'b100, 32'h12,   32'h0,        32'h000000AA, 0));
    vecs.push_back(mk("sw_20",        1, 2'b00, 3'b000, 32'h20,   32'h0,        32'h0,        0));
    vecs.push_back(mk("sh_22",        1, 2'b01, 3'b000, 32'h22,   32'h00008001, 32'h0,        0));
    vecs.push_back(mk("lw_20",        0, 2'b00, 3'b000, 32'h20,   32'h0,        32'h80010000, 0));
    vecs.push_back(mk("lh_22",        0, 2'b00, 3'b001, 32'h22,   32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk("lhu_22",       0, 2'b00, 3'b010, 32'h22,   32'h0,        32'h00008001, 0));
    vecs.push_back(mk("sw_30",        1, 2'b00, 3'b000, 32'h30,   32'h55667788, 32'h0,        0));
    vecs.push_back(mk("sw_33_mis",    1, 2'b00, 3'b000, 32'h33,   32'hCAFEF00D, 32'h55667788, 1));
    vecs.push_back(mk("lw_30_a",      0, 2'b00, 3'b000, 32'h30,   32'h0,        32'h55667788, 0));
    vecs.push_back(mk("sh_31_mis",    1, 2'b01, 3'b000, 32'h31,   32'h0000BEEF, 32'h55667788, 1));
    vecs.push_back(mk("lw_30_b",      0, 2'b00, 3'b000, 32'h30,   32'h0,        32'h55667788, 0));
    vecs.push_back(mk("st_rsv_30",    1, 2'b11, 3'b000, 32'h30,   32'hFFFFFFFF, 32'h55667788, 0));
    vecs.push_back(mk("lw_30_c",      0, 2'b00, 3'b000, 32'h30,   32'h0,        32'h55667788, 0));
    vecs.push_back(mk("sw_4004_alias",1, 2'b00, 3'b000, 32'h4004, 32'h12345678, 32'h0,        0));
    vecs.push_back(mk("lw_4_alias",   0, 2'b00, 3'b000, 32'h4,    32'h0,        32'h12345678, 0));
    vecs.push_back(mk("lh_11_mis",    0, 2'b00, 3'b001, 32'h11,   32'h0,        32'h00003344, 1));
    vecs.push_back(mk("lw_12_mis",    0, 2'b00, 3'b000, 32'h12,   32'h0,        32'h11AA3344, 1));
    vecs.push_back(mk("lb_13",        0, 2'b00, 3'b011, 32'h13,   32'h0,        32'h00000011, 0));
    vecs.push_back(mk("sb_13",        1, 2'b10, 3'b000, 32'h13,   32'h00000080, 32'h11AA3344, 0));
    vecs.push_back(mk("lb_13_neg",    0, 2'b00, 3'b011, 32'h13,   32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk("ld_other_lw",  0, 2'b00, 3'b101, 32'h10,   32'h0,        32'h80AA3344, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      mem_write  = vecs[i].we;
      store_type = vecs[i].st;
      load_type  = vecs[i].lt;
      addr       = vecs[i].a;
      wdata      = vecs[i].wd;
      #1;
      check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, {31'h0, addr_err}, {31'h0, vecs[i].exp_err});
    end

    // Same-cycle read returns old data, next cycle the new word
    @(negedge clk);
    idle();
    mem_write = 1'b1; addr = 32'h4; wdata = 32'hA5A5A5A5;
    #1;
    check("same_cycle_old", rdata, 32'h12345678);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #1;
    check("next_cycle_new", rdata, 32'hA5A5A5A5);

    // Reset pulse mid-sweep restarts the full clear
    @(negedge clk);
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (500) @(posedge clk);
    #3;
    check("mid_sweep_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("async_reset_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    count_busy(cnt);
    check("resweep_len", cnt, 1024);
    check("run_busy_low", {31'h0, busy}, 32'h0);
    read_word("cleared_10", 32'h10, 32'h0);
    read_word("cleared_4", 32'h4, 32'h0);
    read_word("cleared_30", 32'h30, 32'h0);
    read_word("cleared_20", 32'h20, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
